// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control for the RV32 core with a configurable number of stages.
// Tracks per-stage valid/destination state and produces EX forwarding selects,
// load-use interlocks, branch flushes, external-stall freezing and CSR counters.
//
// Ports:
//   clk, rst              core clock (rising edge), asynchronous active-low reset
//   if_*                  fields of the instruction currently in IF
//   br_taken              redirect resolved in EX this cycle
//   ext_stall             memory/UART wait, freezes the whole pipeline
//   fwd_a, fwd_b          EX operand source: 0 = register file, k = stage k result
//   stall_if, flush_if    hold / kill the IF instruction
//   bubble_ex             load a NOP into the IF->EX register
//   adv                   stage registers advance this cycle
//   stage_valid           valid bits of stages 1..STAGES-1 (bit k-1 = stage k)
//   cycle_cnt, instret_cnt  free-running cycle count and retired-instruction count
module pipe_ctrl #(
    parameter int unsigned STAGES     = 3,
    parameter int unsigned LOAD_STAGE = STAGES - 1,
    parameter int unsigned CNT_W      = 64,
    localparam int unsigned FWD_W     = $clog2(STAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [4:0]        if_rs1,
    input  logic [4:0]        if_rs2,
    input  logic              if_rs1_used,
    input  logic              if_rs2_used,
    input  logic [4:0]        if_rd,
    input  logic              if_rd_we,
    input  logic              if_is_load,
    input  logic              br_taken,
    input  logic              ext_stall,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b,
    output logic              stall_if,
    output logic              flush_if,
    output logic              bubble_ex,
    output logic              adv,
    output logic [STAGES-2:0] stage_valid,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret_cnt
);

    // Per-stage state, index k = stage k (1 = EX, STAGES-1 = writeback)
    logic [STAGES-1:1] v_q;
    logic [STAGES-1:1] we_q;
    logic [STAGES-1:1] ld_q;
    logic [4:0]        rd_q [1:STAGES-1];
    // Source operands of the instruction in EX
    logic [4:0]        ex_rs1_q;
    logic [4:0]        ex_rs2_q;
    logic              ex_u1_q;
    logic              ex_u2_q;

    logic              load_use;

    // Load-use: IF reads a register whose producing load will not yet be forwardable
    // when the IF instruction reaches EX (producer then sits at stage k+1).
    always_comb begin
        load_use = 1'b0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            if (v_q[FWD_W'(k)] && we_q[FWD_W'(k)] && ld_q[FWD_W'(k)] &&
                (rd_q[FWD_W'(k)] != 5'd0) && (k + 1 < LOAD_STAGE)) begin
                if ((if_rs1_used && (if_rs1 == rd_q[FWD_W'(k)])) ||
                    (if_rs2_used && (if_rs2 == rd_q[FWD_W'(k)]))) begin
                    load_use = 1'b1;
                end
            end
        end
    end

    // Forwarding: scan oldest to youngest so the youngest eligible producer wins
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int unsigned k = STAGES - 1; k >= 2; k--) begin
            if (v_q[FWD_W'(k)] && we_q[FWD_W'(k)] && (rd_q[FWD_W'(k)] != 5'd0) &&
                (!ld_q[FWD_W'(k)] || (k >= LOAD_STAGE))) begin
                if (ex_u1_q && (ex_rs1_q == rd_q[FWD_W'(k)])) fwd_a = FWD_W'(k);
                if (ex_u2_q && (ex_rs2_q == rd_q[FWD_W'(k)])) fwd_b = FWD_W'(k);
            end
        end
    end

    // Hazard controls; a taken branch cancels the wrong-path interlock
    always_comb begin
        adv         = !ext_stall;
        flush_if    = br_taken;
        bubble_ex   = br_taken | load_use;
        stall_if    = (load_use & ~br_taken) | ext_stall;
        stage_valid = v_q;
    end

    // Stage state and counters; only cycle_cnt moves while frozen
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q         <= '0;
            we_q        <= '0;
            ld_q        <= '0;
            for (int unsigned k = 1; k < STAGES; k++) rd_q[FWD_W'(k)] <= 5'd0;
            ex_rs1_q    <= 5'd0;
            ex_rs2_q    <= 5'd0;
            ex_u1_q     <= 1'b0;
            ex_u2_q     <= 1'b0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (adv) begin
                if (v_q[FWD_W'(STAGES - 1)]) instret_cnt <= instret_cnt + CNT_W'(1);
                for (int unsigned k = 2; k < STAGES; k++) begin
                    v_q[FWD_W'(k)]  <= v_q[FWD_W'(k - 1)];
                    we_q[FWD_W'(k)] <= we_q[FWD_W'(k - 1)];
                    ld_q[FWD_W'(k)] <= ld_q[FWD_W'(k - 1)];
                    rd_q[FWD_W'(k)] <= rd_q[FWD_W'(k - 1)];
                end
                // A bubble is a NOP: no sources, no destination
                if (bubble_ex) begin
                    v_q[1]   <= 1'b0;
                    we_q[1]  <= 1'b0;
                    ld_q[1]  <= 1'b0;
                    rd_q[1]  <= 5'd0;
                    ex_rs1_q <= 5'd0;
                    ex_rs2_q <= 5'd0;
                    ex_u1_q  <= 1'b0;
                    ex_u2_q  <= 1'b0;
                end else begin
                    v_q[1]   <= if_valid;
                    we_q[1]  <= if_rd_we;
                    ld_q[1]  <= if_is_load;
                    rd_q[1]  <= if_rd;
                    ex_rs1_q <= if_rs1;
                    ex_rs2_q <= if_rs2;
                    ex_u1_q  <= if_rs1_used;
                    ex_u2_q  <= if_rs2_used;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl (STAGES=5, LOAD_STAGE=3, CNT_W=32): directed hazard
// scenarios plus random traffic, checked by a queue-based scoreboard against a
// behavioural pipeline model.
module tb_pipe_ctrl;
    localparam int unsigned S  = 5;
    localparam int unsigned LS = 3;
    localparam int unsigned CW = 32;
    localparam int unsigned FW = 3;

    logic          clk;
    logic          rst;
    logic          if_valid;
    logic [4:0]    if_rs1, if_rs2, if_rd;
    logic          if_rs1_used, if_rs2_used, if_rd_we, if_is_load;
    logic          br_taken, ext_stall;
    logic [FW-1:0] fwd_a, fwd_b;
    logic          stall_if, flush_if, bubble_ex, adv;
    logic [S-2:0]  stage_valid;
    logic [CW-1:0] cycle_cnt, instret_cnt;

    pipe_ctrl #(.STAGES(S), .LOAD_STAGE(LS), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_rs1(if_rs1), .if_rs2(if_rs2),
        .if_rs1_used(if_rs1_used), .if_rs2_used(if_rs2_used),
        .if_rd(if_rd), .if_rd_we(if_rd_we), .if_is_load(if_is_load),
        .br_taken(br_taken), .ext_stall(ext_stall),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_if(stall_if), .flush_if(flush_if),
        .bubble_ex(bubble_ex), .adv(adv), .stage_valid(stage_valid),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit       v;
        bit [4:0] rs1, rs2;
        bit       u1, u2;
        bit [4:0] rd;
        bit       we, ld;
    } ins_t;

    typedef struct {
        ins_t i;
        bit   br;
        bit   stall;
    } stim_t;

    typedef struct {
        bit [FW-1:0] fa, fb;
        bit          si, fi, be, ad;
        bit [S-2:0]  sv;
        bit [CW-1:0] cc, ic;
    } exp_t;

    // Reference model: one instruction record per stage plus the two counters
    ins_t          pipe [1:S-1];
    bit [CW-1:0]   m_cyc, m_ret;
    stim_t         cur;
    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
        end
    endtask

    function automatic ins_t nop();
        ins_t r;
        r = '{default: 0};
        return r;
    endfunction

    function automatic ins_t mk(input bit [4:0] rd, input bit we, input bit ld,
                                input bit [4:0] rs1, input bit u1,
                                input bit [4:0] rs2, input bit u2);
        ins_t r;
        r.v = 1'b1; r.rd = rd; r.we = we; r.ld = ld;
        r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
        return r;
    endfunction

    function automatic stim_t st(input ins_t i, input bit br, input bit stall);
        stim_t s;
        s.i = i; s.br = br; s.stall = stall;
        return s;
    endfunction

    function automatic bit produces(input int k, input bit [4:0] r);
        return pipe[k].v && pipe[k].we && (pipe[k].rd != 5'd0) && (pipe[k].rd == r);
    endfunction

    // Any load whose result is not forwardable by the time IF reaches EX
    function automatic bit m_load_use();
        for (int k = 1; k < S; k++) begin
            if (pipe[k].ld && (k + 1 < LS)) begin
                if (cur.i.u1 && cur.i.rs1 != 0 && produces(k, cur.i.rs1)) return 1'b1;
                if (cur.i.u2 && cur.i.rs2 != 0 && produces(k, cur.i.rs2)) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Youngest forwardable producer in stages 2..S-1, else register file
    function automatic bit [FW-1:0] m_fwd(input bit used, input bit [4:0] r);
        if (!used || r == 0) return '0;
        for (int k = 2; k < S; k++)
            if (produces(k, r) && (!pipe[k].ld || k >= LS)) return FW'(k);
        return '0;
    endfunction

    function automatic exp_t m_exp();
        exp_t e;
        bit   lu;
        lu   = m_load_use();
        e.fa = m_fwd(pipe[1].u1, pipe[1].rs1);
        e.fb = m_fwd(pipe[1].u2, pipe[1].rs2);
        e.ad = !cur.stall;
        e.fi = cur.br;
        e.be = cur.br || lu;
        e.si = (lu && !cur.br) || cur.stall;
        for (int k = 1; k < S; k++) e.sv[k-1] = pipe[k].v;
        e.cc = m_cyc;
        e.ic = m_ret;
        return e;
    endfunction

    task automatic m_reset();
        for (int k = 1; k < S; k++) pipe[k] = nop();
        m_cyc = '0;
        m_ret = '0;
    endtask

    task automatic m_clock();
        bit lu;
        if (!rst) begin
            m_reset();
        end else begin
            m_cyc++;
            if (!cur.stall) begin
                lu = m_load_use();
                if (pipe[S-1].v) m_ret++;
                for (int k = S - 1; k >= 2; k--) pipe[k] = pipe[k-1];
                pipe[1] = (cur.br || lu) ? nop() : cur.i;
            end
        end
    endtask

    task automatic apply(input stim_t s);
        if_valid    = s.i.v;
        if_rs1      = s.i.rs1;
        if_rs2      = s.i.rs2;
        if_rs1_used = s.i.u1;
        if_rs2_used = s.i.u2;
        if_rd       = s.i.rd;
        if_rd_we    = s.i.we;
        if_is_load  = s.i.ld;
        br_taken    = s.br;
        ext_stall   = s.stall;
    endtask

    // One clock: model takes the edge, new inputs go out at +1, expectation queued.
    // Returns at +2 so directed checks see settled combinational outputs.
    task automatic step(input stim_t s, input bit r);
        @(posedge clk);
        m_clock();
        #1;
        rst = r;
        cur = s;
        apply(s);
        q.push_back(m_exp());
        #1;
    endtask

    function automatic stim_t rnd();
        stim_t s;
        s.i.v   = ($urandom % 4) != 0;
        s.i.rd  = 5'($urandom % 4);
        s.i.we  = ($urandom % 4) != 0;
        s.i.ld  = s.i.we && (($urandom % 3) == 0);
        s.i.rs1 = 5'($urandom % 4);
        s.i.rs2 = 5'($urandom % 4);
        s.i.u1  = 1'($urandom);
        s.i.u2  = 1'($urandom);
        s.br    = ($urandom % 10) == 0;
        s.stall = ($urandom % 5) == 0;
        return s;
    endfunction

    // Monitor: outputs are presented every cycle; compare at the falling edge
    always @(negedge clk) begin
        exp_t e;
        bit   bad;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("fwd_a", fwd_a, e.fa);
            chk("fwd_b", fwd_b, e.fb);
            chk("stall_if", stall_if, e.si);
            chk("flush_if", flush_if, e.fi);
            chk("bubble_ex", bubble_ex, e.be);
            chk("adv", adv, e.ad);
            chk("stage_valid", stage_valid, e.sv);
            chk("cycle_cnt", cycle_cnt, e.cc);
            chk("instret_cnt", instret_cnt, e.ic);
            // EX must never depend on a youngest producer that is a non-forwardable load
            bad = 1'b0;
            if (dut.v_q[1]) begin
                for (int op = 0; op < 2; op++) begin
                    logic [4:0] r;
                    logic       u;
                    bit         found;
                    r = (op == 0) ? dut.ex_rs1_q : dut.ex_rs2_q;
                    u = (op == 0) ? dut.ex_u1_q : dut.ex_u2_q;
                    found = 1'b0;
                    if (u && r != 5'd0) begin
                        for (int k = 2; k < S; k++) begin
                            if (!found && dut.v_q[FW'(k)] && dut.we_q[FW'(k)] &&
                                dut.rd_q[FW'(k)] == r) begin
                                found = 1'b1;
                                if (dut.ld_q[FW'(k)] && k < LS) bad = 1'b1;
                            end
                        end
                    end
                end
            end
            chk("ex_invariant", 64'(bad), 64'd0);
        end
    end

    initial begin
        stim_t   idle;
        exp_t    e;
        bit [CW-1:0] c0, r0;

        idle = st(nop(), 1'b0, 1'b0);
        rst = 1'b0;
        cur = idle;
        apply(idle);
        m_reset();

        // Reset state with idle inputs
        step(idle, 1'b0);
        chk("rst_adv", adv, 1);
        chk("rst_stage_valid", stage_valid, 0);
        step(idle, 1'b0);
        step(idle, 1'b1);
        step(idle, 1'b1);
        chk("first_cycle", cycle_cnt, 1);

        // add x5,x1,x2 ; sub x6,x5,x3
        step(st(mk(5, 1, 0, 1, 1, 2, 1), 0, 0), 1'b1);
        step(st(mk(6, 1, 0, 5, 1, 3, 1), 0, 0), 1'b1);
        chk("alu_no_stall", stall_if, 0);
        step(idle, 1'b1);
        chk("alu_fwd_a", fwd_a, 2);
        chk("alu_fwd_b", fwd_b, 0);
        repeat (4) step(idle, 1'b1);
        chk("alu_instret", instret_cnt, 2);

        // lw x6,0(x1) ; add x7,x6,x6 -> one bubble then forward from stage 3
        step(st(mk(6, 1, 1, 1, 1, 0, 0), 0, 0), 1'b1);
        step(st(mk(7, 1, 0, 6, 1, 6, 1), 0, 0), 1'b1);
        chk("lu_stall", stall_if, 1);
        chk("lu_bubble", bubble_ex, 1);
        step(st(mk(7, 1, 0, 6, 1, 6, 1), 0, 0), 1'b1);
        chk("lu_stall_once", stall_if, 0);
        chk("lu_bubble_once", bubble_ex, 0);
        step(idle, 1'b1);
        chk("lu_fwd_a", fwd_a, 3);
        chk("lu_fwd_b", fwd_b, 3);

        // Load-use coinciding with a taken branch
        step(st(mk(8, 1, 1, 1, 1, 0, 0), 0, 0), 1'b1);
        step(st(mk(9, 1, 0, 8, 1, 0, 0), 1, 0), 1'b1);
        chk("br_flush", flush_if, 1);
        chk("br_bubble", bubble_ex, 1);
        chk("br_no_stall", stall_if, 0);
        step(idle, 1'b1);
        chk("br_ex_invalid", stage_valid[0], 0);

        // x0 is never forwarded
        step(st(mk(0, 1, 0, 1, 1, 0, 0), 0, 0), 1'b1);
        step(st(mk(10, 1, 0, 0, 1, 0, 1), 0, 0), 1'b1);
        step(idle, 1'b1);
        chk("x0_fwd_a", fwd_a, 0);
        chk("x0_fwd_b", fwd_b, 0);

        // Two writers of x9: youngest (stage 2) wins
        step(st(mk(9, 1, 0, 1, 1, 0, 0), 0, 0), 1'b1);
        step(st(mk(9, 1, 0, 2, 1, 0, 0), 0, 0), 1'b1);
        step(st(mk(11, 1, 0, 9, 1, 9, 1), 0, 0), 1'b1);
        step(idle, 1'b1);
        chk("young_fwd_a", fwd_a, 2);
        chk("young_fwd_b", fwd_b, 2);

        // ext_stall for 4 cycles with a full pipeline
        repeat (4) step(st(mk(12, 1, 0, 0, 0, 0, 0), 0, 0), 1'b1);
        step(st(mk(12, 1, 0, 0, 0, 0, 0), 0, 1), 1'b1);
        chk("stall_adv", adv, 0);
        chk("stall_full", stage_valid, 4'hF);
        c0 = m_cyc;
        r0 = m_ret;
        repeat (3) step(st(mk(12, 1, 0, 0, 0, 0, 0), 0, 1), 1'b1);
        step(st(mk(12, 1, 0, 0, 0, 0, 0), 0, 0), 1'b1);
        chk("stall_cycles", cycle_cnt, 64'(c0 + CW'(4)));
        chk("stall_instret", instret_cnt, 64'(r0));
        chk("stall_sv_kept", stage_valid, 4'hF);

        // Counter wrap: preset both counters to all-ones
        step(idle, 1'b1);
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        force dut.instret_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        release dut.instret_cnt;
        m_cyc = 32'hFFFF_FFFF;
        m_ret = 32'hFFFF_FFFF;
        e = q.pop_back();
        e.cc = m_cyc;
        e.ic = m_ret;
        q.push_back(e);
        step(idle, 1'b1);
        chk("cycle_wrap", cycle_cnt, 0);

        // Random traffic
        for (int n = 0; n < 400; n++) step(rnd(), 1'b1);

        // Asynchronous reset mid-stream
        step(rnd(), 1'b1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_stage_valid", stage_valid, 0);
        chk("arst_cycle", cycle_cnt, 0);
        chk("arst_instret", instret_cnt, 0);
        m_reset();
        void'(q.pop_back());
        q.push_back(m_exp());
        step(idle, 1'b0);
        step(idle, 1'b1);
        for (int n = 0; n < 200; n++) step(rnd(), 1'b1);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
